// File: rtl/csr_access_ctrl_pkg.sv
// Shared widths, Zicsr funct3 encodings and FSM state type for the CSR access port.
package csr_access_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_INSTR_WIDTH = 32;
    localparam int unsigned DEF_CSR_ADDR_W  = 12;
    localparam int unsigned DEF_REG_IDX_W   = 5;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_WB     = 3'd3,
        ST_TRAP   = 3'd4
    } state_e;

endpackage

// File: rtl/csr_op_decode.sv
// Combinational Zicsr decode: access intent, set/clear flavour, operand and bad-op flag.
module csr_op_decode
    import csr_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned REG_IDX_W  = DEF_REG_IDX_W
) (
    input  logic [2:0]            funct3,
    input  logic [REG_IDX_W-1:0]  rd_idx,
    input  logic [REG_IDX_W-1:0]  rs1_idx,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    output logic                  rd_c,
    output logic                  wr_c,
    output logic                  set_c,
    output logic                  clr_c,
    output logic [DATA_WIDTH-1:0] operand_c,
    output logic                  bad_op_c
);

    logic is_rw;

    always_comb begin
        is_rw     = (funct3 == F3_CSRRW) || (funct3 == F3_CSRRWI);
        set_c     = (funct3 == F3_CSRRS) || (funct3 == F3_CSRRSI);
        clr_c     = (funct3 == F3_CSRRC) || (funct3 == F3_CSRRCI);
        bad_op_c  = !(is_rw || set_c || clr_c);
        // Reads are skippable only for RW with rd=x0; writes only for RS/RC with rs1/zimm=0.
        rd_c      = !is_rw || (rd_idx != '0);
        wr_c      = is_rw || (rs1_idx != '0);
        operand_c = funct3[2] ? DATA_WIDTH'(rs1_idx) : rs1_data;
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Initiator side of the machine CSR port: one Zicsr instruction in flight, from decode
// handshake through CSR file access to rd writeback or illegal-instruction trap.
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int unsigned CSR_ADDR_W  = DEF_CSR_ADDR_W,
    parameter int unsigned REG_IDX_W   = DEF_REG_IDX_W
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [INSTR_WIDTH-1:0] req_instr,
    input  logic [2:0]             req_funct3,
    input  logic [CSR_ADDR_W-1:0]  req_csr_addr,
    input  logic [REG_IDX_W-1:0]   req_rd_idx,
    input  logic [REG_IDX_W-1:0]   req_rs1_idx,
    input  logic [DATA_WIDTH-1:0]  req_rs1_data,
    input  logic                   flush,
    output logic [CSR_ADDR_W-1:0]  csr_addr,
    output logic                   mcsr_rd,
    output logic                   mcsr_wr,
    output logic                   valid_mcsr_rd,
    output logic                   valid_mcsr_wr,
    output logic                   mcsr_set,
    output logic                   mcsr_clr,
    output logic [DATA_WIDTH-1:0]  write_data,
    input  logic [DATA_WIDTH-1:0]  read_data,
    input  logic                   csr_illegal_access,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [REG_IDX_W-1:0]   wb_rd_idx,
    output logic [DATA_WIDTH-1:0]  wb_data,
    output logic                   trap_valid,
    output logic [INSTR_WIDTH-1:0] trap_instr
);

    state_e state, state_next;

    logic [INSTR_WIDTH-1:0] lat_instr;
    logic [2:0]             lat_funct3;
    logic [CSR_ADDR_W-1:0]  lat_addr;
    logic [REG_IDX_W-1:0]   lat_rd_idx;
    logic [REG_IDX_W-1:0]   lat_rs1_idx;
    logic [DATA_WIDTH-1:0]  lat_rs1_data;
    logic [DATA_WIDTH-1:0]  wb_data_q;

    logic                  dec_rd;
    logic                  dec_wr;
    logic                  dec_set;
    logic                  dec_clr;
    logic [DATA_WIDTH-1:0] dec_operand;
    logic                  dec_bad_op;

    csr_op_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_IDX_W  (REG_IDX_W)
    ) u_decode (
        .funct3    (lat_funct3),
        .rd_idx    (lat_rd_idx),
        .rs1_idx   (lat_rs1_idx),
        .rs1_data  (lat_rs1_data),
        .rd_c      (dec_rd),
        .wr_c      (dec_wr),
        .set_c     (dec_set),
        .clr_c     (dec_clr),
        .operand_c (dec_operand),
        .bad_op_c  (dec_bad_op)
    );

    // State register
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture on accept; old CSR value captured at the commit cycle
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            lat_instr    <= '0;
            lat_funct3   <= '0;
            lat_addr     <= '0;
            lat_rd_idx   <= '0;
            lat_rs1_idx  <= '0;
            lat_rs1_data <= '0;
            wb_data_q    <= '0;
        end else begin
            if ((state == ST_IDLE) && req_valid) begin
                lat_instr    <= req_instr;
                lat_funct3   <= req_funct3;
                lat_addr     <= req_csr_addr;
                lat_rd_idx   <= req_rd_idx;
                lat_rs1_idx  <= req_rs1_idx;
                lat_rs1_data <= req_rs1_data;
            end
            if (state == ST_ACCESS) begin
                wb_data_q <= read_data;
            end
        end
    end

    // Next state and outputs; all outputs derive from registers only
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        csr_addr      = '0;
        mcsr_rd       = 1'b0;
        mcsr_wr       = 1'b0;
        valid_mcsr_rd = 1'b0;
        valid_mcsr_wr = 1'b0;
        mcsr_set      = 1'b0;
        mcsr_clr      = 1'b0;
        write_data    = '0;
        wb_valid      = 1'b0;
        wb_rd_idx     = '0;
        wb_data       = '0;
        trap_valid    = 1'b0;
        trap_instr    = '0;

        if ((state == ST_CHECK) || (state == ST_ACCESS)) begin
            csr_addr   = lat_addr;
            mcsr_rd    = dec_rd;
            mcsr_wr    = dec_wr;
            mcsr_set   = dec_set;
            mcsr_clr   = dec_clr;
            write_data = dec_operand;
        end

        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (dec_bad_op || csr_illegal_access) begin
                    state_next = ST_TRAP;
                end else begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Commit point: flush no longer has any effect
                valid_mcsr_rd = dec_rd;
                valid_mcsr_wr = dec_wr;
                state_next    = (lat_rd_idx != '0) ? ST_WB : ST_IDLE;
            end
            ST_WB: begin
                wb_valid  = 1'b1;
                wb_rd_idx = lat_rd_idx;
                wb_data   = wb_data_q;
                if (wb_ready || flush) begin
                    state_next = ST_IDLE;
                end
            end
            ST_TRAP: begin
                trap_valid = 1'b1;
                trap_instr = lat_instr;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: acts as decode, CSR file and register file, and predicts
// each instruction's outcome from the Zicsr rules with a flat array model of CSR contents.
module tb_csr_access_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instr = '0;
    logic [2:0]  req_funct3 = '0;
    logic [11:0] req_csr_addr = '0;
    logic [4:0]  req_rd_idx = '0;
    logic [4:0]  req_rs1_idx = '0;
    logic [31:0] req_rs1_data = '0;
    logic        flush = 1'b0;
    logic [11:0] csr_addr;
    logic        mcsr_rd, mcsr_wr, valid_mcsr_rd, valid_mcsr_wr, mcsr_set, mcsr_clr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        csr_illegal_access = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_data;
    logic        trap_valid;
    logic [31:0] trap_instr;

    logic [31:0] file_mem [4096];
    logic [31:0] ref_mem  [4096];
    int n_cmp = 0;
    int n_err = 0;

    always #5 cpu_clk = ~cpu_clk;

    assign read_data = file_mem[csr_addr];

    csr_access_ctrl dut (
        .cpu_clk            (cpu_clk),
        .cpu_rst            (cpu_rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_instr          (req_instr),
        .req_funct3         (req_funct3),
        .req_csr_addr       (req_csr_addr),
        .req_rd_idx         (req_rd_idx),
        .req_rs1_idx        (req_rs1_idx),
        .req_rs1_data       (req_rs1_data),
        .flush              (flush),
        .csr_addr           (csr_addr),
        .mcsr_rd            (mcsr_rd),
        .mcsr_wr            (mcsr_wr),
        .valid_mcsr_rd      (valid_mcsr_rd),
        .valid_mcsr_wr      (valid_mcsr_wr),
        .mcsr_set           (mcsr_set),
        .mcsr_clr           (mcsr_clr),
        .write_data         (write_data),
        .read_data          (read_data),
        .csr_illegal_access (csr_illegal_access),
        .wb_valid           (wb_valid),
        .wb_ready           (wb_ready),
        .wb_rd_idx          (wb_rd_idx),
        .wb_data            (wb_data),
        .trap_valid         (trap_valid),
        .trap_instr         (trap_instr)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issue one instruction from a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [31:0] rs1_data, input bit illegal,
                           input bit flush_chk, input bit flush_acc, input int wb_delay,
                           input bit flush_wb, input bit rst_wb);
        logic [31:0] instr, operand, old_val, new_val;
        logic [31:0] acc_wdata, acc_addr, seen_trap_instr, pend_data;
        logic [11:0] pend_addr;
        bit is_imm, bad, exp_rd, exp_wr, exp_set, exp_clr, exp_access, exp_trap, exp_wb;
        bit pend, acc_set, acc_clr, acc_rd, acc_wr, aborted;
        int n_vrd, n_vwr, n_trap, n_wb, first_wb, done, exp_done, stray_ti;

        instr      = {addr, rs1, f3, rd, 7'h73};
        is_imm     = f3[2];
        bad        = (f3[1:0] == 2'b00);
        operand    = is_imm ? {27'd0, rs1} : rs1_data;
        exp_rd     = (f3[1:0] != 2'b01) || (rd != 0);
        exp_wr     = (f3[1:0] == 2'b01) || (rs1 != 0);
        exp_set    = (f3[1:0] == 2'b10);
        exp_clr    = (f3[1:0] == 2'b11);
        exp_trap   = !flush_chk && (bad || illegal);
        exp_access = !flush_chk && !exp_trap;
        exp_wb     = exp_access && (rd != 0);
        old_val    = ref_mem[addr];
        if (exp_access && exp_wr) begin
            if (exp_set)      new_val = old_val | operand;
            else if (exp_clr) new_val = old_val & ~operand;
            else              new_val = operand;
            ref_mem[addr] = new_val;
        end
        if (flush_chk)     exp_done = 2;
        else if (exp_trap) exp_done = 3;
        else if (!exp_wb)  exp_done = 3;
        else               exp_done = 3 + wb_delay + 1;

        check_eq("ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_instr = instr; req_funct3 = f3; req_csr_addr = addr;
        req_rd_idx = rd; req_rs1_idx = rs1; req_rs1_data = rs1_data;
        csr_illegal_access = illegal;
        n_vrd = 0; n_vwr = 0; n_trap = 0; n_wb = 0; first_wb = -1; done = -1; stray_ti = 0;
        acc_wdata = '0; acc_addr = '0; acc_set = 0; acc_clr = 0; acc_rd = 0; acc_wr = 0;
        seen_trap_instr = '0; pend = 0; pend_addr = '0; pend_data = '0; aborted = 0;

        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge cpu_clk);
            req_valid = 1'b0;
            if (pend) begin
                file_mem[pend_addr] = pend_data;
                pend = 0;
            end
            flush = 1'b0;
            wb_ready = 1'b0;
            if (cyc == 1) begin
                check_eq("check_addr", 64'(csr_addr), 64'(addr));
                check_eq("check_rd_intent", 64'(mcsr_rd), 64'(exp_rd));
                check_eq("check_wr_intent", 64'(mcsr_wr), 64'(exp_wr));
                flush = flush_chk;
            end
            if (cyc == 2 && flush_acc) flush = 1'b1;
            if (valid_mcsr_rd || valid_mcsr_wr) begin
                acc_wdata = write_data; acc_addr = 32'(csr_addr);
                acc_set = mcsr_set; acc_clr = mcsr_clr; acc_rd = mcsr_rd; acc_wr = mcsr_wr;
            end
            if (valid_mcsr_wr) begin
                pend = 1; pend_addr = csr_addr;
                pend_data = mcsr_set ? (read_data | write_data) :
                            mcsr_clr ? (read_data & ~write_data) : write_data;
            end
            n_vrd += int'(valid_mcsr_rd);
            n_vwr += int'(valid_mcsr_wr);
            if (trap_valid) begin
                n_trap++;
                seen_trap_instr = trap_instr;
            end else if (trap_instr != '0) begin
                stray_ti++;
            end
            if (wb_valid) begin
                if (n_wb == 0) first_wb = cyc;
                check_eq("wb_data", 64'(wb_data), 64'(old_val));
                check_eq("wb_rd_idx", 64'(wb_rd_idx), 64'(rd));
                if (rst_wb) begin
                    #3 cpu_rst = 1'b1;
                    #1;
                    check_eq("rst_wb_valid", 64'(wb_valid), 64'd0);
                    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
                    check_eq("rst_strobes", 64'({valid_mcsr_rd, valid_mcsr_wr}), 64'd0);
                    @(negedge cpu_clk);
                    check_eq("rst_hold_idle", 64'({req_ready, wb_valid}), 64'b10);
                    cpu_rst = 1'b0;
                    aborted = 1;
                    n_wb++;
                    break;
                end
                if (n_wb == wb_delay) begin
                    if (flush_wb) flush = 1'b1;
                    else          wb_ready = 1'b1;
                end
                n_wb++;
            end
            if (req_ready) begin
                done = cyc;
                break;
            end
        end
        if (pend) file_mem[pend_addr] = pend_data;
        flush = 1'b0;
        wb_ready = 1'b0;
        csr_illegal_access = 1'b0;

        check_eq("rd_strobes", 64'(n_vrd), 64'(exp_access && exp_rd));
        check_eq("wr_strobes", 64'(n_vwr), 64'(exp_access && exp_wr));
        check_eq("trap_pulses", 64'(n_trap), 64'(exp_trap));
        check_eq("trap_instr_idle_zero", 64'(stray_ti), 64'd0);
        if (exp_trap) check_eq("trap_instr", 64'(seen_trap_instr), 64'(instr));
        if (exp_access) begin
            check_eq("acc_write_data", 64'(acc_wdata), 64'(operand));
            check_eq("acc_addr", 64'(acc_addr), 64'(addr));
            check_eq("acc_set_clr", 64'({acc_set, acc_clr}), 64'({exp_set, exp_clr}));
            check_eq("acc_intent", 64'({acc_rd, acc_wr}), 64'({exp_rd, exp_wr}));
        end
        if (exp_wb) check_eq("wb_first_cycle", 64'(first_wb), 64'd3);
        else        check_eq("wb_absent", 64'(n_wb), 64'd0);
        if (!aborted) check_eq("done_cycle", 64'(done), 64'(exp_done));
        else          check_eq("aborted_expected", 64'(rst_wb && exp_wb), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            file_mem[i] = $urandom;
            ref_mem[i]  = file_mem[i];
        end
        repeat (2) @(negedge cpu_clk);
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        check_eq("rst_outputs", 64'({mcsr_rd, mcsr_wr, valid_mcsr_rd, valid_mcsr_wr,
                                     mcsr_set, mcsr_clr, wb_valid, trap_valid}), 64'd0);
        check_eq("rst_buses", 64'(csr_addr) | 64'(write_data) | 64'(wb_rd_idx)
                              | 64'(wb_data) | 64'(trap_instr), 64'd0);
        cpu_rst = 1'b0;
        @(negedge cpu_clk);

        file_mem[12'h300] = 32'h8; ref_mem[12'h300] = 32'h8;
        run_txn(3'b010, 12'h300, 5'd5, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        file_mem[12'h305] = 32'h0; ref_mem[12'h305] = 32'h0;
        run_txn(3'b001, 12'h305, 5'd7, 5'd3, 32'h8000_0100, 0, 0, 0, 1, 0, 0);
        run_txn(3'b111, 12'h304, 5'd0, 5'd8, 32'h0, 0, 0, 0, 0, 0, 0);
        run_txn(3'b001, 12'hF11, 5'd4, 5'd2, 32'h1234_5678, 1, 0, 0, 0, 0, 0);
        run_txn(3'b100, 12'h300, 5'd4, 5'd2, 32'h1, 0, 0, 0, 0, 0, 0);
        run_txn(3'b001, 12'h341, 5'd9, 5'd1, 32'hAAAA_5555, 0, 1, 0, 0, 0, 0);
        run_txn(3'b011, 12'h344, 5'd6, 5'd1, 32'h0000_00FF, 0, 0, 1, 5, 0, 0);
        run_txn(3'b110, 12'h340, 5'd3, 5'd9, 32'h0, 0, 0, 0, 2, 1, 0);
        run_txn(3'b010, 12'h342, 5'd11, 5'd12, 32'h0F0F_0000, 0, 0, 0, 3, 0, 1);
        run_txn(3'b101, 12'h342, 5'd13, 5'd21, 32'h0, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 200; t++) begin
            logic [11:0] a;
            logic [4:0]  rd, rs1;
            bit          bad_sel;
            a   = 12'h300 + 12'($urandom_range(0, 7));
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            bad_sel = ($urandom_range(0, 5) == 0);
            run_txn(3'($urandom), a, rd, rs1, $urandom, bad_sel,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 4), ($urandom_range(0, 7) == 0), 0);
            repeat ($urandom_range(0, 2)) @(negedge cpu_clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
